mac_stream_mem: RTL and testbench

Matrix storage block for the MAC datapath: holds operand matrices A (M×K), B (K×N) and result matrix C (M×N) with random-access read/write ports, plus a streaming read engine. The engine bursts a whole matrix out with a valid/ready handshake: A row-major, B column-major, C row-major. C writes can optionally accumulate into the stored value. It sits between the host load/unload logic and the MAC array.

---
 rtl/mac_stream_mem.sv | 211 +++++++++++++++++++++
 tb/tb_mac_stream_mem.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_mem.sv
// Matrix store for the MAC datapath: A (MxK), B (KxN), C (MxN) with random-access
// ports, accumulate-on-write for C, and a valid/ready burst engine (A/C row-major, B column-major).
module mac_stream_mem #(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
  input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
  input  logic [$clog2(M)-1:0]                row_addr_a,
  input  logic [$clog2(K)-1:0]                col_addr_a,
  input  logic [$clog2(K)-1:0]                row_addr_b,
  input  logic [$clog2(N)-1:0]                col_addr_b,
  input  logic [$clog2(M)-1:0]                row_addr_c,
  input  logic [$clog2(N)-1:0]                col_addr_c,
  input  logic                                matrix_a_we,
  input  logic                                matrix_b_we,
  input  logic                                matrix_c_we,
  input  logic                                matrix_c_acc,
  input  logic                                matrix_a_re,
  input  logic                                matrix_b_re,
  input  logic                                matrix_c_re,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c,
  input  logic                                stream_start,
  input  logic [1:0]                          stream_sel,
  input  logic                                stream_ready,
  output logic                                stream_valid,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] stream_data,
  output logic                                stream_last,
  output logic [$clog2((M > K) ? M : K)-1:0]  stream_row,
  output logic [$clog2((K > N) ? K : N)-1:0]  stream_col,
  output logic                                stream_busy,
  output logic                                stream_state_dbg
);

  localparam int DW  = DATA_WIDTH_INIT_MATRIX;
  localparam int RW  = DATA_WIDTH_RESULT_MATRIX;
  localparam int MW  = $clog2(M);
  localparam int KW  = $clog2(K);
  localparam int NW  = $clog2(N);
  localparam int SRW = $clog2((M > K) ? M : K);
  localparam int SCW = $clog2((K > N) ? K : N);

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  localparam logic [SRW-1:0] M_LAST_R = SRW'(M-1);
  localparam logic [SRW-1:0] K_LAST_R = SRW'(K-1);
  localparam logic [SCW-1:0] K_LAST_C = SCW'(K-1);
  localparam logic [SCW-1:0] N_LAST_C = SCW'(N-1);

  // Handshake: an element transfers on a rising edge where stream_valid and
  // stream_ready are both 1; while valid is high and ready is low, data,
  // coordinates and last are held unchanged. Valid never drops without a transfer
  // except on reset.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stream_state_t;

  stream_state_t state, next_state;

  logic [DW-1:0] mem_a [M][K];
  logic [DW-1:0] mem_b [K][N];
  logic [RW-1:0] mem_c [M][N];

  logic           fetch, done;
  logic [1:0]     sel_q, f_sel;
  logic [SRW-1:0] f_row;
  logic [SCW-1:0] f_col;
  logic [RW-1:0]  fetch_val;
  logic           fetch_last;
  logic [SCW-1:0] row_col_last;

  // Storage; nonblocking writes give read-before-write on same-edge collisions
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < K; j++) mem_a[i][j] <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < N; j++) mem_b[i][j] <= '0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++) mem_c[i][j] <= '0;
    end else begin
      if (matrix_a_we) mem_a[row_addr_a][col_addr_a] <= data_in_a;
      if (matrix_b_we) mem_b[row_addr_b][col_addr_b] <= data_in_b;
      if (matrix_c_we) begin
        if (matrix_c_acc) mem_c[row_addr_c][col_addr_c] <= mem_c[row_addr_c][col_addr_c] + data_in_c;
        else              mem_c[row_addr_c][col_addr_c] <= data_in_c;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out_a <= '0;
      data_out_b <= '0;
      data_out_c <= '0;
    end else begin
      if (matrix_a_re) data_out_a <= mem_a[row_addr_a][col_addr_a];
      if (matrix_b_re) data_out_b <= mem_b[row_addr_b][col_addr_b];
      if (matrix_c_re) data_out_c <= mem_c[row_addr_c][col_addr_c];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // A and C walk rows; only the column limit differs
  assign row_col_last = (sel_q == SEL_C) ? N_LAST_C : K_LAST_C;

  always_comb begin
    next_state = state;
    fetch      = 1'b0;
    done       = 1'b0;
    f_sel      = sel_q;
    f_row      = '0;
    f_col      = '0;
    case (state)
      IDLE: begin
        if (stream_start && stream_sel != SEL_RSV) begin
          next_state = RUN;
          fetch      = 1'b1;
          f_sel      = stream_sel;
        end
      end
      RUN: begin
        if (stream_ready) begin
          if (stream_last) begin
            next_state = IDLE;
            done       = 1'b1;
          end else begin
            fetch = 1'b1;
            if (sel_q == SEL_B) begin
              if (stream_row == K_LAST_R) begin
                f_row = '0;
                f_col = stream_col + 1'b1;
              end else begin
                f_row = stream_row + 1'b1;
                f_col = stream_col;
              end
            end else begin
              if (stream_col == row_col_last) begin
                f_row = stream_row + 1'b1;
                f_col = '0;
              end else begin
                f_row = stream_row;
                f_col = stream_col + 1'b1;
              end
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fetch_val  = '0;
    fetch_last = 1'b0;
    case (f_sel)
      SEL_A: begin
        fetch_val  = RW'(mem_a[f_row[MW-1:0]][f_col[KW-1:0]]);
        fetch_last = (f_row == M_LAST_R) && (f_col == K_LAST_C);
      end
      SEL_B: begin
        fetch_val  = RW'(mem_b[f_row[KW-1:0]][f_col[NW-1:0]]);
        fetch_last = (f_row == K_LAST_R) && (f_col == N_LAST_C);
      end
      SEL_C: begin
        fetch_val  = mem_c[f_row[MW-1:0]][f_col[NW-1:0]];
        fetch_last = (f_row == M_LAST_R) && (f_col == N_LAST_C);
      end
      default: begin
        fetch_val  = '0;
        fetch_last = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q       <= SEL_A;
      stream_data <= '0;
      stream_row  <= '0;
      stream_col  <= '0;
      stream_last <= 1'b0;
    end else if (fetch) begin
      sel_q       <= f_sel;
      stream_data <= fetch_val;
      stream_row  <= f_row;
      stream_col  <= f_col;
      stream_last <= fetch_last;
    end else if (done) begin
      stream_last <= 1'b0;
    end
  end

  assign stream_valid     = (state == RUN);
  assign stream_busy      = (state == RUN);
  assign stream_state_dbg = state;

endmodule

// File: tb/tb_mac_stream_mem.sv
// Directed + randomized bench for mac_stream_mem with a behavioural matrix model
// and element-order streams derived from the matrix shapes.
module tb_mac_stream_mem;
  localparam int M   = 4;
  localparam int K   = 4;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int RW  = 2*DW + $clog2(K);
  localparam int MW  = $clog2(M);
  localparam int KW  = $clog2(K);
  localparam int NW  = $clog2(N);
  localparam int SRW = $clog2((M > K) ? M : K);
  localparam int SCW = $clog2((K > N) ? K : N);

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [DW-1:0]  data_in_a, data_in_b, data_out_a, data_out_b;
  logic [RW-1:0]  data_in_c, data_out_c, stream_data;
  logic [MW-1:0]  row_addr_a, row_addr_c;
  logic [KW-1:0]  col_addr_a, row_addr_b;
  logic [NW-1:0]  col_addr_b, col_addr_c;
  logic           matrix_a_we, matrix_b_we, matrix_c_we, matrix_c_acc;
  logic           matrix_a_re, matrix_b_re, matrix_c_re;
  logic           stream_start, stream_ready, stream_valid, stream_last, stream_busy;
  logic           stream_state_dbg;
  logic [1:0]     stream_sel;
  logic [SRW-1:0] stream_row;
  logic [SCW-1:0] stream_col;

  mac_stream_mem #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW)) dut (
    .clk(clk), .resetn(resetn),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .data_in_c(data_in_c),
    .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
    .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
    .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
    .matrix_a_we(matrix_a_we), .matrix_b_we(matrix_b_we), .matrix_c_we(matrix_c_we),
    .matrix_c_acc(matrix_c_acc),
    .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re), .matrix_c_re(matrix_c_re),
    .data_out_a(data_out_a), .data_out_b(data_out_b), .data_out_c(data_out_c),
    .stream_start(stream_start), .stream_sel(stream_sel), .stream_ready(stream_ready),
    .stream_valid(stream_valid), .stream_data(stream_data), .stream_last(stream_last),
    .stream_row(stream_row), .stream_col(stream_col), .stream_busy(stream_busy),
    .stream_state_dbg(stream_state_dbg)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ref_a [M][K];
  logic [DW-1:0] ref_b [K][N];
  logic [RW-1:0] ref_c [M][N];

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    matrix_a_we = 0; matrix_b_we = 0; matrix_c_we = 0; matrix_c_acc = 0;
    matrix_a_re = 0; matrix_b_re = 0; matrix_c_re = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < M; i++) for (int j = 0; j < K; j++) ref_a[i][j] = '0;
    for (int i = 0; i < K; i++) for (int j = 0; j < N; j++) ref_b[i][j] = '0;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) ref_c[i][j] = '0;
  endtask

  task automatic write_a(input int r, input int c, input logic [DW-1:0] v);
    row_addr_a = MW'(r); col_addr_a = KW'(c); data_in_a = v; matrix_a_we = 1;
    tick(); matrix_a_we = 0;
    ref_a[r][c] = v;
  endtask

  task automatic write_b(input int r, input int c, input logic [DW-1:0] v);
    row_addr_b = KW'(r); col_addr_b = NW'(c); data_in_b = v; matrix_b_we = 1;
    tick(); matrix_b_we = 0;
    ref_b[r][c] = v;
  endtask

  task automatic write_c(input int r, input int c, input logic [RW-1:0] v, input bit acc);
    row_addr_c = MW'(r); col_addr_c = NW'(c); data_in_c = v; matrix_c_we = 1; matrix_c_acc = acc;
    tick(); matrix_c_we = 0; matrix_c_acc = 0;
    ref_c[r][c] = acc ? ref_c[r][c] + v : v;
  endtask

  task automatic read_c(input int r, input int c);
    row_addr_c = MW'(r); col_addr_c = NW'(c); matrix_c_re = 1;
    tick(); matrix_c_re = 0;
  endtask

  function automatic logic [RW-1:0] model_val(input int sel, input int r, input int c);
    if (sel == 0) return RW'(ref_a[r][c]);
    if (sel == 1) return RW'(ref_b[r][c]);
    return ref_c[r][c];
  endfunction

  // Random plain write to the streamed matrix, landing on the next edge
  task automatic rand_write(input int sel);
    int r, c;
    if ($urandom_range(0, 1) == 0) return;
    if (sel == 0) begin
      r = $urandom_range(0, M-1); c = $urandom_range(0, K-1);
      row_addr_a = MW'(r); col_addr_a = KW'(c); data_in_a = $urandom; matrix_a_we = 1;
      ref_a[r][c] = data_in_a;
    end else if (sel == 1) begin
      r = $urandom_range(0, K-1); c = $urandom_range(0, N-1);
      row_addr_b = KW'(r); col_addr_b = NW'(c); data_in_b = $urandom; matrix_b_we = 1;
      ref_b[r][c] = data_in_b;
    end else begin
      r = $urandom_range(0, M-1); c = $urandom_range(0, N-1);
      row_addr_c = MW'(r); col_addr_c = NW'(c); data_in_c = {$urandom, $urandom, $urandom};
      matrix_c_we = 1;
      ref_c[r][c] = data_in_c;
    end
  endtask

  // rmode: 0 ready always, 1 ready toggles starting high, 2 random ready
  task automatic run_burst(input int sel, input int rmode, input bit do_wr,
                           input int poke_edge, input int exp_edges);
    int rq[$];
    int cq[$];
    int n, beat, edges, cols;
    logic [RW-1:0] pending;
    bit rdy;
    if (sel == 1) begin
      for (int c = 0; c < N; c++) for (int r = 0; r < K; r++) begin rq.push_back(r); cq.push_back(c); end
    end else begin
      cols = (sel == 0) ? K : N;
      for (int r = 0; r < M; r++) for (int c = 0; c < cols; c++) begin rq.push_back(r); cq.push_back(c); end
    end
    n = rq.size();
    stream_sel = 2'(sel); stream_start = 1; stream_ready = 0;
    pending = model_val(sel, rq[0], cq[0]);
    if (do_wr) rand_write(sel);
    tick(); stream_start = 0; clear_strobes();
    edges = 0; beat = 0;
    while (beat < n && edges < 400) begin
      if (rmode == 0)      rdy = 1;
      else if (rmode == 1) rdy = (edges % 2 == 0);
      else                 rdy = 1'($urandom_range(0, 1));
      stream_ready = rdy;
      check($sformatf("valid_b%0d", beat), RW'(stream_valid), RW'(1));
      check($sformatf("data_b%0d", beat), stream_data, pending);
      if (rdy) begin
        check($sformatf("row_b%0d", beat), RW'(stream_row), RW'(rq[beat]));
        check($sformatf("col_b%0d", beat), RW'(stream_col), RW'(cq[beat]));
        check($sformatf("last_b%0d", beat), RW'(stream_last), RW'(beat == n-1));
        if (beat < n-1) pending = model_val(sel, rq[beat+1], cq[beat+1]);
        beat++;
      end
      if (edges == poke_edge) begin stream_start = 1; stream_sel = 2'd0; end
      if (do_wr) rand_write(sel);
      tick(); stream_start = 0; clear_strobes(); edges++;
    end
    stream_ready = 0;
    check("burst_beats", RW'(beat), RW'(n));
    check("end_busy", RW'(stream_busy), RW'(0));
    check("end_valid", RW'(stream_valid), RW'(0));
    check("end_last", RW'(stream_last), RW'(0));
    if (exp_edges > 0) check("burst_edges", RW'(edges), RW'(exp_edges));
  endtask

  localparam int A_INIT [16] = '{4,3,2,5, 3,4,5,2, 5,2,4,3, 2,5,3,4};
  localparam int B_INIT [16] = '{7,6,5,8, 6,7,8,5, 8,5,7,6, 5,8,6,7};

  initial begin
    resetn = 0;
    data_in_a = '0; data_in_b = '0; data_in_c = '0;
    row_addr_a = '0; col_addr_a = '0; row_addr_b = '0; col_addr_b = '0;
    row_addr_c = '0; col_addr_c = '0;
    clear_strobes();
    stream_start = 0; stream_sel = 0; stream_ready = 0;
    clear_model();
    #23;
    check("rst_out_a", RW'(data_out_a), RW'(0));
    check("rst_out_c", data_out_c, RW'(0));
    check("rst_sdata", stream_data, RW'(0));
    check("rst_valid", RW'(stream_valid), RW'(0));
    check("rst_busy", RW'(stream_busy), RW'(0));
    check("rst_last", RW'(stream_last), RW'(0));
    resetn = 1;
    tick();

    for (int i = 0; i < 16; i++) write_a(i / K, i % K, DW'(A_INIT[i]));
    for (int i = 0; i < 16; i++) begin
      row_addr_a = MW'(i / K); col_addr_a = KW'(i % K); matrix_a_re = 1;
      tick(); matrix_a_re = 0;
      check($sformatf("rd_a_%0d", i), RW'(data_out_a), RW'(A_INIT[i]));
    end

    // Same-edge write/read returns the old value
    row_addr_a = 0; col_addr_a = 0; data_in_a = 9; matrix_a_we = 1; matrix_a_re = 1;
    tick(); clear_strobes();
    check("collide_old", RW'(data_out_a), RW'(4));
    matrix_a_re = 1; tick(); clear_strobes();
    check("collide_new", RW'(data_out_a), RW'(9));
    ref_a[0][0] = 9;
    write_a(0, 0, 4);

    run_burst(0, 0, 0, -1, 16);

    for (int i = 0; i < 16; i++) write_b(i / N, i % N, DW'(B_INIT[i]));
    run_burst(1, 0, 0, -1, 16);
    run_burst(1, 1, 0, -1, 31);

    write_c(1, 2, 94, 0);
    write_c(1, 2, 6, 1);
    read_c(1, 2);
    check("c_acc_100", data_out_c, RW'(100));
    write_c(0, 0, 1, 0);
    write_c(0, 0, {RW{1'b1}}, 1);
    read_c(0, 0);
    check("c_acc_wrap", data_out_c, RW'(0));
    row_addr_c = 1; col_addr_c = 2; data_in_c = 50; matrix_c_acc = 1;
    tick(); clear_strobes();
    read_c(1, 2);
    check("c_acc_no_we", data_out_c, ref_c[1][2]);

    for (int i = 0; i < 6; i++) write_c($urandom_range(0, M-1), $urandom_range(0, N-1), {$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    run_burst(2, 0, 0, 5, 16);

    // Reset mid-burst at beat 7
    stream_sel = 2; stream_start = 1; stream_ready = 1;
    tick(); stream_start = 0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("c_pre_rst_%0d", i), stream_data, ref_c[i / N][i % N]);
      tick();
    end
    check("c_beat7", stream_data, ref_c[7 / N][7 % N]);
    resetn = 0; #1;
    check("midrst_valid", RW'(stream_valid), RW'(0));
    check("midrst_busy", RW'(stream_busy), RW'(0));
    check("midrst_last", RW'(stream_last), RW'(0));
    check("midrst_data", stream_data, RW'(0));
    check("midrst_row", RW'(stream_row), RW'(0));
    stream_ready = 0;
    tick();
    resetn = 1;
    clear_model();
    tick();
    read_c(1, 2);
    check("c_after_rst", data_out_c, RW'(0));

    stream_sel = 3; stream_start = 1;
    tick(); stream_start = 0;
    check("sel3_busy", RW'(stream_busy), RW'(0));
    check("sel3_valid", RW'(stream_valid), RW'(0));

    for (int i = 0; i < M*K; i++) write_a(i / K, i % K, $urandom);
    run_burst(0, 0, 0, -1, 16);
    run_burst(0, 2, 1, -1, 0);
    for (int i = 0; i < K*N; i++) write_b(i / N, i % N, $urandom);
    run_burst(1, 2, 1, -1, 0);
    for (int i = 0; i < M*N; i++) write_c(i / N, i % N, {$urandom, $urandom, $urandom}, 0);
    run_burst(2, 2, 1, -1, 0);
    run_burst(2, 0, 1, -1, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
